// File: rtl/tapu_pkg.sv
// Shared types and helpers for the parametrised TAPU stream front end:
// FSM state encoding, array mode codes and the flush-length rule.
package tapu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } tapu_state_e;

    localparam logic [1:0] MODE_MATMUL = 2'b00;
    localparam logic [1:0] MODE_FPMUL  = 2'b10;
    localparam logic [1:0] MODE_FPADD  = 2'b11;

    // Cycles from the first FLUSH cycle until the PSU results are settled.
    function automatic int tapu_flush_len(input int idx, input int rows, input int cols,
                                          input int arr_lat, input logic [1:0] mode);
        return idx * rows + rows - 1
             + ((idx == 0 && mode == MODE_MATMUL) ? cols - 1 : 0)
             + arr_lat;
    endfunction

endpackage

// File: rtl/tapu_stream_skew.sv
// skew_line: zero-reset delay line of LEN stages; LEN==0 degenerates to a wire.
module skew_line
    import tapu_pkg::*;
#(
    parameter int DW  = 8,
    parameter int LEN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    generate
        if (LEN == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_sr
            logic [LEN-1:0][DW-1:0] sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < LEN; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[LEN-1];
        end
    endgenerate

endmodule

// File: rtl/tapu_stream.sv
// TAPU stream front end: valid/ready X/Y intake, per-row/column input skew,
// and a Moore FSM sequencing clear/feed/flush/drain for one output tile.
module tapu_stream
    import tapu_pkg::*;
#(
    parameter int   TAPU_IDX     = 0,
    parameter int   ROWS         = 4,
    parameter int   COLS         = 16,
    parameter int   LEFT_WIDTH   = 8,
    parameter int   TOP_WIDTH    = 48,
    parameter int   BOTTOM_WIDTH = 48,
    parameter int   ARR_LAT      = 2,
    parameter int   K_MAX        = 1024,
    localparam int  CNT_W        = $clog2(K_MAX + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_in,
    input  logic [1:0]                          mode_sel_in,
    input  logic [CNT_W-1:0]                    cfg_k_in,
    output logic                                busy_out,
    output logic                                done_out,
    input  logic                                s_valid_in,
    output logic                                s_ready_out,
    input  logic [ROWS-1:0][LEFT_WIDTH-1:0]     s_x_in,
    input  logic [COLS-1:0][TOP_WIDTH-1:0]      s_y_in,
    output logic [ROWS-1:0][LEFT_WIDTH-1:0]     arr_x_out,
    output logic [COLS-1:0][TOP_WIDTH-1:0]      arr_y_out,
    output logic [1:0]                          arr_mode_out,
    output logic                                arr_psu_clr_out,
    input  logic [COLS-1:0][BOTTOM_WIDTH-1:0]   arr_z_in,
    output logic                                m_valid_out,
    input  logic                                m_ready_in,
    output logic [COLS-1:0][BOTTOM_WIDTH-1:0]   m_z_out
);

    localparam int F_MAX = tapu_flush_len(TAPU_IDX, ROWS, COLS, ARR_LAT, MODE_MATMUL);
    localparam int FW    = (F_MAX < 2) ? 1 : $clog2(F_MAX + 1);

    tapu_state_e state_q, state_d;

    logic [1:0]                          mode_q;
    logic [CNT_W-1:0]                    k_q;
    logic [CNT_W-1:0]                    beat_cnt;
    logic [FW-1:0]                       flush_cnt;
    logic [FW-1:0]                       f_len;
    logic [COLS-1:0][BOTTOM_WIDTH-1:0]   m_z_q;
    logic [ROWS-1:0][LEFT_WIDTH-1:0]     x_head;
    logic [COLS-1:0][TOP_WIDTH-1:0]      y_head;
    logic [COLS-1:0][TOP_WIDTH-1:0]      y_skew;
    logic                                accept;
    logic                                beat_last;
    logic                                flush_last;
    logic                                y_skew_en;

    assign accept     = s_valid_in && (state_q == ST_FEED);
    assign beat_last  = (beat_cnt + CNT_W'(1)) == k_q;
    assign f_len      = FW'(tapu_flush_len(TAPU_IDX, ROWS, COLS, ARR_LAT, mode_q));
    // Degenerate zero/one-cycle flushes both leave after a single FLUSH cycle.
    assign flush_last = (f_len <= FW'(1)) || (flush_cnt == f_len - FW'(1));
    assign y_skew_en  = (TAPU_IDX == 0) && (mode_q == MODE_MATMUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_in) state_d = ST_CLR;
            ST_CLR:   state_d = (k_q == '0) ? ST_FLUSH : ST_FEED;
            ST_FEED:  if (accept && beat_last) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_last) state_d = ST_DRAIN;
            ST_DRAIN: if (m_ready_in) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            k_q       <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            m_z_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && start_in) begin
                mode_q <= mode_sel_in;
                k_q    <= cfg_k_in;
            end
            if (state_q == ST_CLR) beat_cnt <= '0;
            else if (accept)       beat_cnt <= beat_cnt + CNT_W'(1);
            if (state_q == ST_FLUSH) flush_cnt <= flush_cnt + FW'(1);
            else                     flush_cnt <= '0;
            if (state_q == ST_FLUSH && flush_last) m_z_q <= arr_z_in;
        end
    end

    // Head registers inject zeros on every non-accepting cycle so the skew
    // lines carry bubbles rather than stale data across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_head <= '0;
            y_head <= '0;
        end else begin
            x_head <= accept ? s_x_in : '0;
            y_head <= accept ? s_y_in : '0;
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_x
            skew_line #(.DW(LEFT_WIDTH), .LEN(TAPU_IDX * ROWS + r)) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (x_head[r]),
                .q     (arr_x_out[r])
            );
        end
        for (genvar c = 0; c < COLS; c++) begin : g_y
            skew_line #(.DW(TOP_WIDTH), .LEN((TAPU_IDX == 0) ? c : 0)) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (y_head[c]),
                .q     (y_skew[c])
            );
        end
    endgenerate

    assign arr_y_out       = y_skew_en ? y_skew : y_head;
    assign arr_mode_out    = mode_q;
    assign arr_psu_clr_out = (state_q == ST_CLR);
    assign s_ready_out     = (state_q == ST_FEED);
    assign busy_out        = (state_q != ST_IDLE);
    assign m_valid_out     = (state_q == ST_DRAIN);
    assign done_out        = (state_q == ST_DONE);
    assign m_z_out         = m_z_q;

endmodule

// File: tb/tb_tapu_stream.sv
// Bench for tapu_stream: two instances (cascade index 0 and 2) share one
// randomized stimulus stream and are checked cycle by cycle against a timeline model.
module tb_tapu_stream;

    localparam int ROWS    = 4;
    localparam int COLS    = 16;
    localparam int LW      = 8;
    localparam int TW      = 48;
    localparam int BW      = 48;
    localparam int ARR_LAT = 2;
    localparam int K_MAX   = 1024;
    localparam int CNT_W   = $clog2(K_MAX + 1);
    localparam int IDX2    = 2;
    localparam int HIST    = 8192;
    localparam int CW      = COLS * TW;
    localparam int BIG     = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                      start, s_valid, m_ready;
    logic [1:0]                mode_sel;
    logic [CNT_W-1:0]          cfg_k;
    logic [ROWS-1:0][LW-1:0]   s_x;
    logic [COLS-1:0][TW-1:0]   s_y;
    logic [COLS-1:0][BW-1:0]   arr_z;

    logic                      busy, done, s_ready, clr, m_valid;
    logic [1:0]                arr_mode;
    logic [ROWS-1:0][LW-1:0]   arr_x;
    logic [COLS-1:0][TW-1:0]   arr_y;
    logic [COLS-1:0][BW-1:0]   m_z;

    logic                      busy2, done2, s_ready2, clr2, m_valid2;
    logic [1:0]                arr_mode2;
    logic [ROWS-1:0][LW-1:0]   arr_x2;
    logic [COLS-1:0][TW-1:0]   arr_y2;
    logic [COLS-1:0][BW-1:0]   m_z2;

    tapu_stream #(.TAPU_IDX(0), .ROWS(ROWS), .COLS(COLS), .LEFT_WIDTH(LW), .TOP_WIDTH(TW),
                  .BOTTOM_WIDTH(BW), .ARR_LAT(ARR_LAT), .K_MAX(K_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_in(start), .mode_sel_in(mode_sel), .cfg_k_in(cfg_k),
        .busy_out(busy), .done_out(done), .s_valid_in(s_valid), .s_ready_out(s_ready),
        .s_x_in(s_x), .s_y_in(s_y), .arr_x_out(arr_x), .arr_y_out(arr_y),
        .arr_mode_out(arr_mode), .arr_psu_clr_out(clr), .arr_z_in(arr_z),
        .m_valid_out(m_valid), .m_ready_in(m_ready), .m_z_out(m_z));

    tapu_stream #(.TAPU_IDX(IDX2), .ROWS(ROWS), .COLS(COLS), .LEFT_WIDTH(LW), .TOP_WIDTH(TW),
                  .BOTTOM_WIDTH(BW), .ARR_LAT(ARR_LAT), .K_MAX(K_MAX)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_in(start), .mode_sel_in(mode_sel), .cfg_k_in(cfg_k),
        .busy_out(busy2), .done_out(done2), .s_valid_in(s_valid), .s_ready_out(s_ready2),
        .s_x_in(s_x), .s_y_in(s_y), .arr_x_out(arr_x2), .arr_y_out(arr_y2),
        .arr_mode_out(arr_mode2), .arr_psu_clr_out(clr2), .arr_z_in(arr_z),
        .m_valid_out(m_valid2), .m_ready_in(1'b1), .m_z_out(m_z2));

    int errors = 0;
    int checks = 0;

    // Reference history: what was accepted in each cycle, and arr_z per cycle.
    bit                      hv [HIST];
    logic [ROWS-1:0][LW-1:0] hx [HIST];
    logic [COLS-1:0][TW-1:0] hy [HIST];
    logic [COLS-1:0][BW-1:0] zh [HIST];

    // Tile timeline: start cycle, first FLUSH cycle, handshake cycle.
    int cyc = 0;
    int ts = BIG, fs = BIG, hs = BIG;
    int f1 = 0, f2 = 0;
    int tile_k = 0, taken = 0, gap_pct = 0, stall_left = 0;
    logic [31:0] gap_mask = '0;
    logic [1:0]  tile_mode = '0, lat_mode = '0;
    bit          cnt_x = 1'b0;

    function automatic int flen(input int idx, input logic [1:0] mode);
        return idx * ROWS + (ROWS - 1) + ((idx == 0 && mode == 2'b00) ? COLS - 1 : 0) + ARR_LAT;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Check this cycle's outputs, then drive and record this cycle's inputs.
    task automatic step();
        logic [ROWS-1:0][LW-1:0] ex, ex2;
        logic [COLS-1:0][TW-1:0] ey, ey2;
        bit feed, drain, acc;
        int d, rel;
        if (cyc == ts + 1) lat_mode = tile_mode;
        feed  = (cyc >= ts + 2) && (cyc < fs);
        drain = (cyc >= fs + f1) && (cyc <= hs);

        chk("busy",     CW'(busy),     CW'((cyc > ts) && (cyc <= hs + 1)));
        chk("s_ready",  CW'(s_ready),  CW'(feed));
        chk("psu_clr",  CW'(clr),      CW'(cyc == ts + 1));
        chk("m_valid",  CW'(m_valid),  CW'(drain));
        chk("done",     CW'(done),     CW'(cyc == hs + 1));
        chk("arr_mode", CW'(arr_mode), CW'(lat_mode));
        if (drain) chk("m_z", CW'(m_z), CW'(zh[(fs + f1 - 1) % HIST]));

        chk("busy2",     CW'(busy2),     CW'((cyc > ts) && (cyc <= fs + f2 + 1)));
        chk("s_ready2",  CW'(s_ready2),  CW'(feed));
        chk("psu_clr2",  CW'(clr2),      CW'(cyc == ts + 1));
        chk("m_valid2",  CW'(m_valid2),  CW'(cyc == fs + f2));
        chk("done2",     CW'(done2),     CW'(cyc == fs + f2 + 1));
        chk("arr_mode2", CW'(arr_mode2), CW'(lat_mode));
        if (cyc == fs + f2) chk("m_z2", CW'(m_z2), CW'(zh[(fs + f2 - 1) % HIST]));

        for (int r = 0; r < ROWS; r++) begin
            d = cyc - 1 - r;
            ex[r] = (d >= 0 && hv[d % HIST]) ? hx[d % HIST][r] : '0;
            d = cyc - 1 - IDX2 * ROWS - r;
            ex2[r] = (d >= 0 && hv[d % HIST]) ? hx[d % HIST][r] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            d = (lat_mode == 2'b00) ? cyc - 1 - c : cyc - 1;
            ey[c] = (d >= 0 && hv[d % HIST]) ? hy[d % HIST][c] : '0;
            d = cyc - 1;
            ey2[c] = (d >= 0 && hv[d % HIST]) ? hy[d % HIST][c] : '0;
        end
        chk("arr_x",  CW'(arr_x),  CW'(ex));
        chk("arr_y",  CW'(arr_y),  CW'(ey));
        chk("arr_x2", CW'(arr_x2), CW'(ex2));
        chk("arr_y2", CW'(arr_y2), CW'(ey2));

        rel = cyc - ts;
        start    = (cyc == ts) ? 1'b1 : (((cyc == ts + 1) || feed) ? 1'($urandom) : 1'b0);
        mode_sel = (cyc == ts) ? tile_mode : 2'($urandom);
        cfg_k    = (cyc == ts) ? CNT_W'(tile_k) : CNT_W'($urandom);
        if (feed) s_valid = !(rel >= 0 && rel < 32 && gap_mask[rel]) && ($urandom_range(99) >= gap_pct);
        else      s_valid = 1'($urandom);
        for (int r = 0; r < ROWS; r++) s_x[r] = cnt_x ? LW'(taken + 1) : LW'($urandom);
        for (int c = 0; c < COLS; c++) begin
            s_y[c]   = TW'({$urandom, $urandom});
            arr_z[c] = BW'({$urandom, $urandom});
        end
        if (drain) begin
            if (stall_left > 0) begin m_ready = 1'b0; stall_left--; end
            else m_ready = 1'b1;
        end else begin
            m_ready = 1'($urandom);
        end

        acc = feed && s_valid;
        hv[cyc % HIST] = acc;
        hx[cyc % HIST] = s_x;
        hy[cyc % HIST] = s_y;
        zh[cyc % HIST] = arr_z;
        if (acc) begin
            taken++;
            if (taken == tile_k) fs = cyc + 1;
        end
        if (drain && m_ready) hs = cyc;
        tick();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",  CW'({busy, busy2}), '0);
        chk("rst_ctrl",  CW'({s_ready, clr, m_valid, done, arr_mode}), '0);
        chk("rst_ctrl2", CW'({s_ready2, clr2, m_valid2, done2, arr_mode2}), '0);
        chk("rst_x",     CW'({arr_x, arr_x2}), '0);
        chk("rst_y",     CW'(arr_y | arr_y2), '0);
        chk("rst_mz",    CW'(m_z | m_z2), '0);
        for (int i = 0; i < HIST; i++) hv[i] = 1'b0;
        ts = BIG; fs = BIG; hs = BIG; lat_mode = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_tile(input int k, input logic [1:0] mode, input int gap,
                            input logic [31:0] gmask, input int stall, input bit pat,
                            input int rst_at);
        bit finished;
        tile_k = k; tile_mode = mode; gap_pct = gap; gap_mask = gmask;
        stall_left = stall; cnt_x = pat; taken = 0;
        f1 = flen(0, mode);
        f2 = flen(IDX2, mode);
        ts = cyc;
        fs = (k == 0) ? cyc + 2 : BIG;
        hs = BIG;
        finished = 1'b0;
        for (int n = 0; n < 2 * k + 400; n++) begin
            if (cyc > hs + 1 && cyc > fs + f2 + 1) begin finished = 1'b1; break; end
            step();
            if (rst_at > 0 && taken == rst_at) begin do_reset(); return; end
        end
        if (!finished) begin
            checks++;
            errors++;
            $error("FAIL tile_timeout k=%0d got=busy exp=idle", k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; mode_sel = '0; cfg_k = '0;
        s_x = '0; s_y = '0; arr_z = '0;
        tick();
        chk("reset_mz", CW'(m_z | m_z2), '0);
        idle(2);
        rst_n = 1'b1;
        idle(3);

        run_tile(3, 2'b00, 0, 32'h0, 0, 1'b1, -1);                   // matmul basic
        idle(16);
        run_tile(4, 2'b00, 0, 32'h28, 0, 1'b1, -1);                  // gaps at cycles 3,5
        idle(16);
        run_tile(0, 2'b00, 0, 32'h0, 0, 1'b0, -1);                   // k=0
        idle(16);
        run_tile(5, 2'b00, 20, 32'h0, 10, 1'b0, -1);                 // output backpressure
        idle(16);
        run_tile(6, 2'b11, 30, 32'h0, 2, 1'b0, -1);                  // fp add
        idle(16);
        run_tile(7, 2'b10, 0, 32'h0, 0, 1'b0, -1);                   // fp mul
        idle(16);
        run_tile(8, 2'b00, 0, 32'h0, 0, 1'b1, 2);                    // reset mid-FEED
        idle(4);
        run_tile(5, 2'b00, 0, 32'h0, 0, 1'b1, -1);
        idle(16);
        run_tile(K_MAX, 2'b11, 10, 32'h0, 0, 1'b0, -1);              // k = K_MAX
        idle(16);
        for (int t = 0; t < 4; t++) begin
            run_tile($urandom_range(20, 1), ($urandom_range(1) != 0) ? 2'b00 : 2'b11,
                     $urandom_range(40), 32'h0, $urandom_range(5), 1'b0, -1);
            idle(16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
